seq_always_rr_mux: RTL
======================

Name: seq_always_rr_mux

Overview:
- Parametrised N-channel arbitrated mux with one registered output stage and a valid/ready handshake on every port.
- Generalises the combinational if/case/default-assignment selectors to any width and channel count. Adds a sequential output register, a fixed-priority or round-robin mode, and backpressure.
- Elaboration fixture for always_ff with asynchronous reset, nested if/case, and default-then-override assignments inside sequential processes.

Parameters:
DATA_WIDTH, 4, bit width of each channel's data and of out_data
NUM_CH, 4, number of input channels (>=1)
DEFAULT_VALUE, '0, value of out_data while out_valid=0 (reset and after drain)

Ports:
clk  input  1  clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
mode  input  1  0 = fixed priority (lowest index wins), 1 = round-robin
in_valid  input  NUM_CH  per-channel valid
in_data  input  NUM_CH*DATA_WIDTH  channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]
in_ready  output  NUM_CH  per-channel ready (one-hot or zero)
out_valid  output  1  output register holds a beat
out_ready  input  1  downstream accepts beat
out_data  output  DATA_WIDTH  registered data
out_ch  output  CH_W  source channel of held beat; CH_W = max(1,$clog2(NUM_CH))

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. All state clears immediately on rst_n falling, independent of clk.
- Reset values: out_valid=0, out_data=DEFAULT_VALUE, out_ch=0, rr pointer ptr=0. in_ready=0 while rst_n=0.
- States (encoded by out_valid):
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- load_en = !out_valid || out_ready. Registered stage with pass-through on simultaneous pop and push.
- Grant (combinational, default grant=0 then override):
  - mode=0: lowest index i with in_valid[i]=1.
  - mode=1: first i with in_valid[i]=1, searching ptr, ptr+1, …, NUM_CH-1, 0, …, ptr-1 (wrap-around).
- in_ready = grant & {NUM_CH{load_en}}. At most one bit set. in_ready may depend on in_valid. Upstream must not depend on in_ready to raise valid.
- Transfer on channel k (in_valid[k] & in_ready[k]) at edge t:
  - At t+1: out_valid=1, out_data=in_data[k], out_ch=k. Latency is 1 cycle.
  - If mode=1: ptr <= (k+1) mod NUM_CH. If mode=0: ptr unchanged.
- Transitions:
  - EMPTY, no valid: stay EMPTY. out_data and out_ch hold DEFAULT_VALUE and 0.
  - EMPTY, grant: -> FULL.
  - FULL, out_ready=0: hold all outputs stable, in_ready=0.
  - FULL, out_ready=1, grant: stay FULL with new beat. Full throughput, one beat per cycle.
  - FULL, out_ready=1, no grant: -> EMPTY. out_data <= DEFAULT_VALUE, out_ch <= 0.
- Mode change: takes effect on the next arbitration cycle. ptr retained across mode changes.
- NUM_CH=1: grant = in_valid[0]. ptr stays 0. out_ch always 0.
- Data width: no truncation or extension. out_data is exactly DATA_WIDTH bits.
- Reset mid-operation: a held beat is dropped. No beat is accepted in the cycle rst_n deasserts unless rst_n is high at that edge.

Optional Feature:
- Macro: SEQ_ALWAYS_RR_MUX_STATS_EN.
- Defined:
  - Adds output port beat_count, 8 bits.
  - Increments by 1 on each output handshake (out_valid & out_ready).
  - Saturates at 255. Resets to 0.
- Undefined: port and counter absent. All other behaviour identical.

Test Plan (NUM_CH=4, DATA_WIDTH=4, DEFAULT_VALUE=0):
1. Reset then idle: rst_n=0, then 1, with in_valid=0 -> out_valid=0, out_data=0, out_ch=0, in_ready=0000 for 5 cycles.
2. Fixed priority: mode=0, in_valid=1010, ch1=0x5, ch3=0xC, out_ready=1 -> in_ready=0010. Next cycle out_data=0x5, out_ch=1. ch1 granted every cycle while in_valid[1]=1.
3. Round-robin fairness: mode=1, in_valid=1111, data ch0..3=0x1,0x2,0x3,0x4, out_ready=1 -> out_data sequence 1,2,3,4,1,… with out_ch 0,1,2,3,0.
4. Backpressure: FULL with out_data=0x7 and out_ready=0 for 3 cycles, in_valid=0001 -> in_ready=0000, out_data stays 0x7. out_ready=1 -> next cycle out_data=ch0 value.
5. Drain to default: FULL with 0x9, out_ready=1, in_valid=0000 -> next cycle out_valid=0, out_data=0, out_ch=0.
6. Async reset mid-stream: rst_n falls between edges while FULL with 0xA -> out_valid=0 and out_data=0 immediately. After release with mode=1, in_valid=1111 -> first grant is ch0 (ptr=0). With STATS_EN defined, beat_count=0 after reset and saturates at 255 after 300 handshakes.

Source files
------------

// File: rtl/seq_always_rr_mux.sv
// ---------------------------------------------------------------------------
// seq_always_rr_mux
//
// N-channel arbitrated multiplexer with one registered output stage.
// Each input channel and the output use a valid/ready handshake. The
// arbiter uses fixed priority (lowest index wins) or round-robin
// (search starts at a rotating pointer). The output register accepts a
// new beat whenever it is empty or is being drained in the same cycle,
// so back-to-back transfers run at one beat per clock.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst_n      in   asynchronous active-low reset
//   mode       in   0 = fixed priority, 1 = round-robin
//   in_valid   in   [NUM_CH]               per-channel valid
//   in_data    in   [NUM_CH*DATA_WIDTH]    channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_ready   out  [NUM_CH]               per-channel ready (one-hot or zero)
//   out_valid  out  output register holds a beat
//   out_ready  in   downstream accepts the held beat
//   out_data   out  [DATA_WIDTH]           held beat (DEFAULT_VALUE when empty)
//   out_ch     out  [CH_W]                 source channel of the held beat
//   beat_count out  [8]  only when SEQ_ALWAYS_RR_MUX_STATS_EN is defined;
//                        saturating count of output handshakes
//
// Optional feature macro: SEQ_ALWAYS_RR_MUX_STATS_EN
// ---------------------------------------------------------------------------
module seq_always_rr_mux #(
  parameter int                    DATA_WIDTH    = 4,
  parameter int                    NUM_CH        = 4,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_VALUE = '0,
  localparam int                   CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mode,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]            in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]              out_ch
`ifdef SEQ_ALWAYS_RR_MUX_STATS_EN
  ,
  output logic [7:0]                   beat_count
`endif
);

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic [CH_W-1:0]       out_ch_q,    out_ch_d;
  logic [CH_W-1:0]       ptr_q,       ptr_d;

  logic [NUM_CH-1:0]     grant;
  logic [CH_W-1:0]       grant_idx;
  logic [CH_W-1:0]       cand;
  logic                  found;
  logic                  load_en;
  logic                  take;

  // The register can accept a beat when empty, or when its current beat
  // leaves in this same cycle (pass-through on simultaneous pop and push).
  assign load_en = !out_valid_q || out_ready;

  // Arbiter: default no grant, then the first valid channel in search order
  // overrides it. Round-robin visits ptr, ptr+1, ... with wrap-around.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    if (mode == 1'b0) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!found && in_valid[i]) begin
          found     = 1'b1;
          grant_idx = CH_W'(i);
        end
      end
    end else begin
      for (int j = 0; j < NUM_CH; j++) begin
        cand = CH_W'((int'(ptr_q) + j) % NUM_CH);
        if (!found && in_valid[cand]) begin
          found     = 1'b1;
          grant_idx = cand;
        end
      end
    end
    if (found) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // Held low during reset even though the empty register would otherwise
  // advertise readiness.
  assign in_ready = rst_n ? (grant & {NUM_CH{load_en}}) : '0;
  assign take     = load_en && found;

  // Next state: hold by default, then load a new beat or drain to default.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      if (take) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        out_ch_d    = grant_idx;
        if (mode) begin
          ptr_d = CH_W'((int'(grant_idx) + 1) % NUM_CH);
        end
      end else begin
        out_valid_d = 1'b0;
        out_data_d  = DEFAULT_VALUE;
        out_ch_d    = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= DEFAULT_VALUE;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

`ifdef SEQ_ALWAYS_RR_MUX_STATS_EN
  logic [7:0] beat_count_q, beat_count_d;

  // Saturating count of beats leaving the output register.
  always_comb begin
    beat_count_d = beat_count_q;
    if (out_valid_q && out_ready && (beat_count_q != 8'hFF)) begin
      beat_count_d = beat_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_count_q <= 8'd0;
    end else begin
      beat_count_q <= beat_count_d;
    end
  end

  assign beat_count = beat_count_q;
`endif

endmodule
